seg_scan_mux: RTL and testbench

//  Parametrised multiplexed 7-segment scan driver for NUM_DIGITS common-select digits.

---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_hex_decode.sv | 32 +++
 rtl/seg_scan_mux.sv | 151 +++++++++++++++
 tb/tb_seg_scan_mux.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: digit width and active-high
// glyphs in {g,f,e,d,c,b,a} order.
package seg_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-high 7-segment glyph (0-9, A b C d E F).
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] nibble,
    output logic [6:0]         glyph
);

    always_comb begin
        glyph = SEG_OFF;
        case (nibble)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            4'hF: glyph = SEG_F;
            default: glyph = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scan driver with per-frame input snapshot, DP mask and
// leading-zero blanking. Define SEG_GHOST_BLANK_EN for a dark gap between digits.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int DIGIT_TICKS = 50000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit DIG_ACT_LOW = 1'b1,
    parameter int BLANK_TICKS = 500
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]         dp_mask,
    input  logic                          blank_lz,
    output logic [7:0]                    segsig,
    output logic [NUM_DIGITS-1:0]         bitsig,
    output logic                          frame_done
);

    localparam int CNT_W = $clog2(DIGIT_TICKS + BLANK_TICKS);
    localparam int IDX_W = $clog2(NUM_DIGITS);
`ifdef SEG_GHOST_BLANK_EN
    localparam int PERIOD = DIGIT_TICKS + BLANK_TICKS;
`else
    localparam int PERIOD = DIGIT_TICKS;
`endif
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_POL  = {8{SEG_ACT_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_POL  = {NUM_DIGITS{DIG_ACT_LOW}};

    logic                          run_reg, run_next;
    logic [CNT_W-1:0]              cnt_reg, cnt_next;
    logic [IDX_W-1:0]              idx_reg, idx_next;
    logic [DIGIT_W*NUM_DIGITS-1:0] snap_value_reg, snap_value_next;
    logic [NUM_DIGITS-1:0]         snap_dp_reg, snap_dp_next;
    logic                          snap_blz_reg, snap_blz_next;
    logic [7:0]                    segsig_reg;
    logic [NUM_DIGITS-1:0]         bitsig_reg;
    logic                          frame_done_reg;

    // Scan sequencing; snapshot is taken only when a frame starts.
    always_comb begin
        run_next        = run_reg;
        cnt_next        = cnt_reg;
        idx_next        = idx_reg;
        snap_value_next = snap_value_reg;
        snap_dp_next    = snap_dp_reg;
        snap_blz_next   = snap_blz_reg;
        if (!enable) begin
            run_next = 1'b0;
            cnt_next = '0;
            idx_next = '0;
        end else if (!run_reg) begin
            run_next        = 1'b1;
            cnt_next        = '0;
            idx_next        = '0;
            snap_value_next = value;
            snap_dp_next    = dp_mask;
            snap_blz_next   = blank_lz;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
            if (idx_reg == IDX_LAST) begin
                idx_next        = '0;
                snap_value_next = value;
                snap_dp_next    = dp_mask;
                snap_blz_next   = blank_lz;
            end else begin
                idx_next = idx_reg + IDX_W'(1);
            end
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Output decode works on the state being entered so the pins change on the
    // same edge as the index.
    logic [DIGIT_W-1:0]    nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank_dig;
    logic [NUM_DIGITS-1:0] dig_on;
    logic [DIGIT_W-1:0]    cur_nib;
    logic [6:0]            glyph;
    logic                  lit;
    logic [7:0]            seg_on;
    logic                  frame_done_next;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign nib[gi] = snap_value_next[DIGIT_W*gi +: DIGIT_W];
        if (gi == 0) begin : g_lsd
            assign blank_dig[gi] = 1'b0;
        end else begin : g_upper
            assign blank_dig[gi] = snap_blz_next &&
                                   ~|snap_value_next[DIGIT_W*NUM_DIGITS-1:DIGIT_W*gi];
        end
        assign dig_on[NUM_DIGITS-1-gi] = lit && (idx_next == IDX_W'(gi));
    end

    assign cur_nib = nib[idx_next];

    seg_hex_decode u_decode (
        .nibble (cur_nib),
        .glyph  (glyph)
    );

`ifdef SEG_GHOST_BLANK_EN
    assign lit = run_next && (cnt_next < CNT_W'(DIGIT_TICKS));
`else
    assign lit = run_next;
`endif

    always_comb begin
        seg_on = 8'h00;
        if (lit) begin
            seg_on = {snap_dp_next[idx_next], blank_dig[idx_next] ? SEG_OFF : glyph};
        end
    end

    assign frame_done_next = run_next && (idx_next == IDX_LAST) && (cnt_next == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_reg        <= 1'b0;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            snap_value_reg <= '0;
            snap_dp_reg    <= '0;
            snap_blz_reg   <= 1'b0;
            segsig_reg     <= SEG_POL;
            bitsig_reg     <= DIG_POL;
            frame_done_reg <= 1'b0;
        end else begin
            run_reg        <= run_next;
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            snap_value_reg <= snap_value_next;
            snap_dp_reg    <= snap_dp_next;
            snap_blz_reg   <= snap_blz_next;
            segsig_reg     <= seg_on ^ SEG_POL;
            bitsig_reg     <= dig_on ^ DIG_POL;
            frame_done_reg <= frame_done_next;
        end
    end

    assign segsig     = segsig_reg;
    assign bitsig     = bitsig_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: frame-position model checked every cycle, plus pinned
// hand-computed glyph/select values at chosen edges.
module tb_seg_scan_mux;

    localparam int N  = 6;
    localparam int DT = 4;
    localparam int BT = 2;
`ifdef SEG_GHOST_BLANK_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif
    localparam int P     = GHOST ? DT + BT : DT;
    localparam int FRAME = N * P;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [23:0] value;
    logic [5:0]  dp_mask;
    logic        blank_lz;
    logic [7:0]  segsig;
    logic [5:0]  bitsig;
    logic        frame_done;

    seg_scan_mux #(
        .NUM_DIGITS  (N),
        .DIGIT_TICKS (DT),
        .SEG_ACT_LOW (1'b1),
        .DIG_ACT_LOW (1'b1),
        .BLANK_TICKS (BT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .value      (value),
        .dp_mask    (dp_mask),
        .blank_lz   (blank_lz),
        .segsig     (segsig),
        .bitsig     (bitsig),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       fd;
        logic [5:0] bits;
        logic [7:0] seg;
    } pins_t;

    function automatic logic [6:0] glyph_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Pins after the tn-th enabled edge, from the position within the frame.
    function automatic pins_t model_out(input int tn, input logic [23:0] v,
                                        input logic [5:0] d, input logic b);
        pins_t      o;
        int         p, dg, off;
        logic [7:0] lit_seg;
        logic [23:0] upper;
        o.seg  = 8'hFF;
        o.bits = 6'h3F;
        o.fd   = 1'b0;
        if (tn > 0) begin
            p   = (tn - 1) % FRAME;
            dg  = p / P;
            off = p % P;
            o.fd = (p == FRAME - 1);
            if (off < DT) begin
                upper   = v >> (4 * dg);
                lit_seg = {d[dg], glyph_of(upper[3:0])};
                if (b && dg != 0 && upper == 24'h0) lit_seg[6:0] = 7'h00;
                o.seg  = ~lit_seg;
                o.bits = ~(6'b100000 >> dg);
            end
        end
        return o;
    endfunction

    int          t;
    int          tn;
    logic [23:0] m_val, sv;
    logic [5:0]  m_dp, sd;
    logic        m_blz, sb;
    pins_t       exp_pins;

    always_comb begin
        tn = enable ? t + 1 : 0;
        sv = m_val;
        sd = m_dp;
        sb = m_blz;
        if (enable && (t % FRAME) == 0) begin
            sv = value;
            sd = dp_mask;
            sb = blank_lz;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            t        <= 0;
            m_val    <= '0;
            m_dp     <= '0;
            m_blz    <= 1'b0;
            exp_pins <= {1'b0, 6'h3F, 8'hFF};
        end else begin
            t        <= tn;
            m_val    <= sv;
            m_dp     <= sd;
            m_blz    <= sb;
            exp_pins <= model_out(tn, sv, sd, sb);
        end
    end

    int         vectors = 0;
    int         miscompares = 0;
    logic       check_en = 1'b0;
    logic       pin_valid = 1'b0;
    string      pin_name = "";
    logic [7:0] pin_seg = 8'h00;
    logic [5:0] pin_bit = 6'h00;
    logic       pin_fd = 1'b0;

    always @(negedge clk) begin
        if (check_en) begin
            vectors++;
            if (segsig !== exp_pins.seg || bitsig !== exp_pins.bits || frame_done !== exp_pins.fd) begin
                miscompares++;
                $display("FAIL model t=%0t seg=%h want %h bitsig=%b want %b frame_done=%b want %b",
                         $time, segsig, exp_pins.seg, bitsig, exp_pins.bits, frame_done, exp_pins.fd);
            end
            if (pin_valid) begin
                vectors++;
                if (segsig !== pin_seg || bitsig !== pin_bit || frame_done !== pin_fd) begin
                    miscompares++;
                    $display("FAIL %s t=%0t seg=%h want %h bitsig=%b want %b frame_done=%b want %b",
                             pin_name, $time, segsig, pin_seg, bitsig, pin_bit, frame_done, pin_fd);
                end
            end
        end
    end

    int e = 0;

    task automatic pin(input string nm, input logic [7:0] s, input logic [5:0] b, input logic f);
        pin_name  = nm;
        pin_seg   = s;
        pin_bit   = b;
        pin_fd    = f;
        pin_valid = 1'b1;
        @(negedge clk);
        #1;
        pin_valid = 1'b0;
    endtask

    task automatic goto(input int target);
        repeat (target - e) @(posedge clk);
        #1;
        e = target;
    endtask

    task automatic restart();
        enable = 1'b0;
        @(posedge clk);
        #1;
        pin("disable", 8'hFF, 6'h3F, 1'b0);
        enable = 1'b1;
        @(posedge clk);
        #1;
        e = 1;
    endtask

    initial begin
        reset    = 1'b0;
        enable   = 1'b0;
        value    = 24'h123456;
        dp_mask  = 6'b000000;
        blank_lz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        pin("reset", 8'hFF, 6'h3F, 1'b0);

        reset  = 1'b1;
        enable = 1'b1;
        e      = 0;
        goto(1);
        pin("d0_6", 8'h82, 6'b011111, 1'b0);
        goto(1 + P);
        pin("d1_5", 8'h92, 6'b101111, 1'b0);
        goto(1 + 5 * P);
        pin("d5_1", 8'hF9, 6'b111110, 1'b0);
        goto(6 * P);
        pin("frame_done", GHOST ? 8'hFF : 8'hF9, GHOST ? 6'h3F : 6'b111110, 1'b1);

        goto(9 * P + 1);
        pin("d3_old", 8'hB0, 6'b111011, 1'b0);
        value = 24'hABCDEF;
        goto(10 * P + 1);
        pin("d4_old", 8'hA4, 6'b111101, 1'b0);
        goto(12 * P + 1);
        pin("new_F", 8'h8E, 6'b011111, 1'b0);
        goto(13 * P + 1);
        pin("new_E", 8'h86, 6'b101111, 1'b0);

        value    = 24'h000070;
        blank_lz = 1'b1;
        restart();
        pin("lz_d0", 8'hC0, 6'b011111, 1'b0);
        goto(1 + P);
        pin("lz_d1", 8'hF8, 6'b101111, 1'b0);
        goto(1 + 2 * P);
        pin("lz_d2", 8'hFF, 6'b110111, 1'b0);
        goto(2 + 2 * P);

        value   = 24'h000000;
        dp_mask = 6'b000100;
        restart();
        pin("zero_d0", 8'hC0, 6'b011111, 1'b0);
        goto(1 + P);
        pin("zero_d1", 8'hFF, 6'b101111, 1'b0);
        goto(1 + 2 * P);
        pin("zero_dp2", 8'h7F, 6'b110111, 1'b0);

        value    = 24'h00000A;
        dp_mask  = 6'b000001;
        blank_lz = 1'b0;
        restart();
        pin("hexA_dp", 8'h08, 6'b011111, 1'b0);
        goto(1 + DT);
        pin("after_d0", GHOST ? 8'hFF : 8'hC0, GHOST ? 6'h3F : 6'b101111, 1'b0);

        goto(e + 2);
        #1;
        reset = 1'b0;
        pin("async_rst", 8'hFF, 6'h3F, 1'b0);
        reset = 1'b1;
        e     = 0;
        goto(1);
        pin("rst_restart", 8'h08, 6'b011111, 1'b0);

        value    = 24'h9876BC;
        dp_mask  = 6'b101010;
        blank_lz = 1'b1;
        restart();
        goto(FRAME / 2);
        value = 24'h00C0DE;
        goto(3 * FRAME);

        value    = 24'h0000F0;
        dp_mask  = 6'b110000;
        restart();
        goto(2 * FRAME + 5);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
